// File: rtl/ddr3_dfi_responder_if.sv
// ----------------------------------------------------------------------------
// ddr3_dfi_responder_if
// Bundles the DFI signals between a DDR3 controller and the DFI-side responder.
//   master modport : controller side, drives command/write data, samples read
//                    data and the responder's error flags.
//   slave modport  : responder side (ddr3_dfi_responder).
// Signals:
//   dfi_cke_i, dfi_reset_n_i, dfi_cs_n_i, dfi_ras_n_i, dfi_cas_n_i,
//   dfi_we_n_i, dfi_odt_i     : DFI control strobes
//   dfi_bank_i, dfi_addr_i    : bank / row-or-column address (A10 = AP/all)
//   dfi_wren_i, dfi_mask_i,
//   dfi_data_i                : write data beat, mask bit 1 = byte not written
//   dfi_rden_i                : accepted for compatibility only
//   dfi_valid_o, dfi_data_o   : read data beat (data is zero when not valid)
//   dfi_rddata_dnv_o          : always zero
//   err_o, err_code_o         : sticky protocol error and first error code
// ----------------------------------------------------------------------------
interface ddr3_dfi_responder_if #(
    parameter int DDR_ROW_BITS   = 15,
    parameter int DDR_DATA_WIDTH = 32,
    parameter int DDR_DQM_WIDTH  = DDR_DATA_WIDTH / 8
);
    logic                      dfi_cke_i;
    logic                      dfi_reset_n_i;
    logic                      dfi_cs_n_i;
    logic                      dfi_ras_n_i;
    logic                      dfi_cas_n_i;
    logic                      dfi_we_n_i;
    logic                      dfi_odt_i;
    logic [2:0]                dfi_bank_i;
    logic [DDR_ROW_BITS-1:0]   dfi_addr_i;
    logic                      dfi_wren_i;
    logic [DDR_DQM_WIDTH-1:0]  dfi_mask_i;
    logic [DDR_DATA_WIDTH-1:0] dfi_data_i;
    logic                      dfi_rden_i;
    logic                      dfi_valid_o;
    logic [DDR_DATA_WIDTH-1:0] dfi_data_o;
    logic [1:0]                dfi_rddata_dnv_o;
    logic                      err_o;
    logic [2:0]                err_code_o;

    modport master (
        output dfi_cke_i, dfi_reset_n_i, dfi_cs_n_i, dfi_ras_n_i, dfi_cas_n_i,
               dfi_we_n_i, dfi_odt_i, dfi_bank_i, dfi_addr_i, dfi_wren_i,
               dfi_mask_i, dfi_data_i, dfi_rden_i,
        input  dfi_valid_o, dfi_data_o, dfi_rddata_dnv_o, err_o, err_code_o
    );

    modport slave (
        input  dfi_cke_i, dfi_reset_n_i, dfi_cs_n_i, dfi_ras_n_i, dfi_cas_n_i,
               dfi_we_n_i, dfi_odt_i, dfi_bank_i, dfi_addr_i, dfi_wren_i,
               dfi_mask_i, dfi_data_i, dfi_rden_i,
        output dfi_valid_o, dfi_data_o, dfi_rddata_dnv_o, err_o, err_code_o
    );
endinterface

// File: rtl/ddr3_dfi_responder.sv
// ----------------------------------------------------------------------------
// ddr3_dfi_responder
// DFI-side responder that stands in for a DDR3 PHY. Decodes DFI commands,
// tracks open rows per bank, captures 4-beat write bursts into local storage
// and replays 4-beat read bursts after DDR_RD_LATENCY cycles.
//
// Ports:
//   clock   : sole clock, rising edge
//   reset_n : asynchronous active-low reset
//   dfi     : ddr3_dfi_responder_if.slave (all DFI and error signals)
//
// Build option DDR3_DFI_RESP_CHECK_EN:
//   defined   - protocol checker present; err_o/err_code_o latch the first
//               violation; RD/WR to a closed bank is rejected.
//   undefined - no checker, err_o/err_code_o are 0; RD/WR to a closed bank
//               runs with the bank's last latched row.
// ----------------------------------------------------------------------------
module ddr3_dfi_responder #(
    parameter int DDR_WR_LATENCY = 6,
    parameter int DDR_RD_LATENCY = 5,
    parameter int DDR_ROW_BITS   = 15,
    parameter int DDR_COL_BITS   = 9,
    parameter int DDR_DATA_WIDTH = 32,
    parameter int DDR_DQM_WIDTH  = DDR_DATA_WIDTH / 8,
    parameter int MEM_ADDR_BITS  = 10
) (
    input  logic                 clock,
    input  logic                 reset_n,
    ddr3_dfi_responder_if.slave  dfi
);
    localparam logic [2:0] CMD_REF = 3'b001;
    localparam logic [2:0] CMD_PRE = 3'b010;
    localparam logic [2:0] CMD_ACT = 3'b011;
    localparam logic [2:0] CMD_WR  = 3'b100;
    localparam logic [2:0] CMD_RD  = 3'b101;

    // Full {bank,row,col[CSB:2]} burst address before truncation to storage.
    localparam int IDX_FULL  = 3 + DDR_ROW_BITS + DDR_COL_BITS - 2;
    localparam int HI_BITS   = MEM_ADDR_BITS - 2;
    localparam int WDL_DEPTH = DDR_WR_LATENCY + 3;
    localparam int RDL_DEPTH = DDR_RD_LATENCY + 2;
    localparam int MEM_DEPTH = 1 << MEM_ADDR_BITS;

    // ------------------------------------------------------------------
    // Command decode
    // ------------------------------------------------------------------
    logic [2:0]              w_cmd;
    logic                    w_sel;
    logic                    w_dec;
    logic                    w_is_act;
    logic                    w_is_pre;
    logic                    w_is_ref;
    logic                    w_is_wr;
    logic                    w_is_rd;
    logic                    w_bank_open;
    logic                    w_rd_go;
    logic                    w_wr_go;
    logic [DDR_ROW_BITS-1:0] w_row;
    logic [DDR_COL_BITS-1:0] w_col;
    logic [IDX_FULL-1:0]     w_full;
    logic [HI_BITS-1:0]      w_base_hi;

    logic [7:0]              r_open;
    logic [DDR_ROW_BITS-1:0] r_row [8];

    assign w_cmd    = {dfi.dfi_ras_n_i, dfi.dfi_cas_n_i, dfi.dfi_we_n_i};
    assign w_sel    = dfi.dfi_reset_n_i & ~dfi.dfi_cs_n_i;
    assign w_dec    = w_sel & dfi.dfi_cke_i;
    assign w_is_act = w_dec & (w_cmd == CMD_ACT);
    assign w_is_pre = w_dec & (w_cmd == CMD_PRE);
    assign w_is_ref = w_dec & (w_cmd == CMD_REF);
    assign w_is_wr  = w_dec & (w_cmd == CMD_WR);
    assign w_is_rd  = w_dec & (w_cmd == CMD_RD);

    assign w_bank_open = r_open[dfi.dfi_bank_i];
    assign w_row       = r_row[dfi.dfi_bank_i];
    assign w_col       = dfi.dfi_addr_i[DDR_COL_BITS-1:0];
    assign w_full      = {dfi.dfi_bank_i, w_row, w_col[DDR_COL_BITS-1:2]};
    // Beat bits [1:0] are appended per beat in the delay-line taps.
    assign w_base_hi   = w_full[HI_BITS-1:0];

`ifdef DDR3_DFI_RESP_CHECK_EN
    assign w_rd_go = w_is_rd & w_bank_open;
    assign w_wr_go = w_is_wr & w_bank_open;
`else
    assign w_rd_go = w_is_rd;
    assign w_wr_go = w_is_wr;
`endif

    // Bank table: ACT opens/latches row, PRE closes, auto-precharge closes.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_open <= 8'h00;
            for (int b = 0; b < 8; b++) begin
                r_row[b] <= '0;
            end
        end else begin
            if (w_is_act) begin
                r_open[dfi.dfi_bank_i] <= 1'b1;
                r_row[dfi.dfi_bank_i]  <= dfi.dfi_addr_i;
            end else if (w_is_pre) begin
                if (dfi.dfi_addr_i[10]) begin
                    r_open <= 8'h00;
                end else begin
                    r_open[dfi.dfi_bank_i] <= 1'b0;
                end
            end else if ((w_rd_go | w_wr_go) & dfi.dfi_addr_i[10]) begin
                r_open[dfi.dfi_bank_i] <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Write and read delay lines; stage k holds a command issued k cycles ago.
    // ------------------------------------------------------------------
    logic [WDL_DEPTH:1] r_wv;
    logic [HI_BITS-1:0] r_wi [1:WDL_DEPTH];
    logic [RDL_DEPTH:1] r_rv;
    logic [HI_BITS-1:0] r_ri [1:RDL_DEPTH];

    // Shift accepted WR/RD burst addresses down their delay lines.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wv <= '0;
            r_rv <= '0;
            for (int k = 1; k <= WDL_DEPTH; k++) begin
                r_wi[k] <= '0;
            end
            for (int k = 1; k <= RDL_DEPTH; k++) begin
                r_ri[k] <= '0;
            end
        end else begin
            r_wv[1] <= w_wr_go;
            r_wi[1] <= w_base_hi;
            r_rv[1] <= w_rd_go;
            r_ri[1] <= w_base_hi;
            for (int k = 2; k <= WDL_DEPTH; k++) begin
                r_wv[k] <= r_wv[k-1];
                r_wi[k] <= r_wi[k-1];
            end
            for (int k = 2; k <= RDL_DEPTH; k++) begin
                r_rv[k] <= r_rv[k-1];
                r_ri[k] <= r_ri[k-1];
            end
        end
    end

    logic                     w_wexp;
    logic [MEM_ADDR_BITS-1:0] w_widx;
    logic                     w_rexp;
    logic [MEM_ADDR_BITS-1:0] w_ridx;

    // Pick the expected write beat and the read beat to fetch this cycle.
    // Overlap only arises from a flagged spacing error; the youngest burst wins.
    always_comb begin
        w_wexp = 1'b0;
        w_widx = '0;
        w_rexp = 1'b0;
        w_ridx = '0;
        for (int i = 3; i >= 0; i--) begin
            if (r_wv[DDR_WR_LATENCY + i]) begin
                w_wexp = 1'b1;
                w_widx = {r_wi[DDR_WR_LATENCY + i], 2'(i)};
            end else begin
                w_wexp = w_wexp;
            end
            if (r_rv[DDR_RD_LATENCY - 1 + i]) begin
                w_rexp = 1'b1;
                w_ridx = {r_ri[DDR_RD_LATENCY - 1 + i], 2'(i)};
            end else begin
                w_rexp = w_rexp;
            end
        end
    end

    // ------------------------------------------------------------------
    // Beat storage (not reset) and registered read port
    // ------------------------------------------------------------------
    logic [DDR_DATA_WIDTH-1:0] r_mem [MEM_DEPTH];
    logic                      r_valid;
    logic [DDR_DATA_WIDTH-1:0] r_data;

    // Byte-masked write of each expected beat that carries dfi_wren_i.
    always_ff @(posedge clock) begin
        if (w_wexp & dfi.dfi_wren_i) begin
            for (int b = 0; b < DDR_DQM_WIDTH; b++) begin
                if (!dfi.dfi_mask_i[b]) begin
                    r_mem[w_widx][8*b +: 8] <= dfi.dfi_data_i[8*b +: 8];
                end
            end
        end
    end

    // Read-data register; data forced to zero between beats.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            r_valid <= w_rexp;
            r_data  <= w_rexp ? r_mem[w_ridx] : '0;
        end
    end

    assign dfi.dfi_valid_o      = r_valid;
    assign dfi.dfi_data_o       = r_data;
    assign dfi.dfi_rddata_dnv_o = 2'b00;

    // ------------------------------------------------------------------
    // Protocol checker
    // ------------------------------------------------------------------
`ifdef DDR3_DFI_RESP_CHECK_EN
    logic [2:0] r_rd_since;
    logic [2:0] r_wr_since;
    logic [2:0] w_err_code;
    logic       r_err;
    logic [2:0] r_err_code;
    logic       w_cke_low_cmd;

    // A real command issued with CKE low is itself a violation.
    assign w_cke_low_cmd = w_sel & ~dfi.dfi_cke_i &
                           ((w_cmd == CMD_ACT) | (w_cmd == CMD_WR) | (w_cmd == CMD_RD));

    // Classify this cycle's violation, if any (0 = none).
    always_comb begin
        w_err_code = 3'd0;
        if (w_cke_low_cmd) begin
            w_err_code = 3'd7;
        end else if (w_is_act & w_bank_open) begin
            w_err_code = 3'd1;
        end else if ((w_is_rd | w_is_wr) & ~w_bank_open) begin
            w_err_code = 3'd2;
        end else if (w_is_ref & (|r_open)) begin
            w_err_code = 3'd3;
        end else if ((w_is_rd & (r_rd_since < 3'd4)) | (w_is_wr & (r_wr_since < 3'd4))) begin
            w_err_code = 3'd4;
        end else if (dfi.dfi_wren_i & ~w_wexp) begin
            w_err_code = 3'd5;
        end else if (~dfi.dfi_wren_i & w_wexp) begin
            w_err_code = 3'd6;
        end else begin
            w_err_code = 3'd0;
        end
    end

    // Cycles since last RD/WR, saturating at 4 ("far enough").
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_since <= 3'd4;
            r_wr_since <= 3'd4;
        end else begin
            if (w_is_rd) begin
                r_rd_since <= 3'd1;
            end else if (r_rd_since < 3'd4) begin
                r_rd_since <= r_rd_since + 3'd1;
            end
            if (w_is_wr) begin
                r_wr_since <= 3'd1;
            end else if (r_wr_since < 3'd4) begin
                r_wr_since <= r_wr_since + 3'd1;
            end
        end
    end

    // Sticky error: only the first code is kept until reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_err      <= 1'b0;
            r_err_code <= 3'd0;
        end else if (!r_err && (w_err_code != 3'd0)) begin
            r_err      <= 1'b1;
            r_err_code <= w_err_code;
        end
    end

    assign dfi.err_o      = r_err;
    assign dfi.err_code_o = r_err_code;

    logic w_unused;
    assign w_unused = ^{dfi.dfi_odt_i, dfi.dfi_rden_i, w_col[1:0],
                        w_full[IDX_FULL-1:HI_BITS]};
`else
    assign dfi.err_o      = 1'b0;
    assign dfi.err_code_o = 3'd0;

    logic w_unused;
    assign w_unused = ^{dfi.dfi_odt_i, dfi.dfi_rden_i, w_col[1:0],
                        w_full[IDX_FULL-1:HI_BITS], w_is_ref, w_bank_open};
`endif

endmodule
